svi_serial_sink: RTL



---
 rtl/svi_serial_pkg.sv | 15 +
 rtl/svi_serial_sink_if.sv | 12 +
 rtl/svi_sat_counter.sv | 32 +++
 rtl/svi_serial_sink.sv | 107 ++++++++++
 4 files changed

// File: rtl/svi_serial_pkg.sv
// Shared types and helpers for the serial SVI sink.
// Imported by the sink top and its sub-blocks.
package svi_serial_pkg;

   typedef enum logic [0:0] {
      IDLE,
      SHIFT
   } sink_state_t;

   // Bit counter width: enough to hold WIDTH itself.
   function automatic int bitcnt_w(int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/svi_serial_sink_if.sv
// Scalar SVI bundle: z = frame start, y = bit strobe, x = data.
// P drives the bundle, C only observes it.
interface I;

   logic z;
   logic y;
   logic x;

   modport P (output z, output y, output x);
   modport C (input z, input y, input x);

endinterface

// File: rtl/svi_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones once reached.
module svi_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_q
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_q = cnt_q;

endmodule

// File: rtl/svi_serial_sink.sv
// Serial SVI sink: deserialises z/y/x frames into WIDTH-bit words,
// flags framing errors and counts good frames.
module svi_serial_sink
   import svi_serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_srst,
   I.C                      p,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_err,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_count
);

   localparam int BW = bitcnt_w(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   sink_state_t      state_q;
   logic [BW-1:0]    bitcnt_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_base;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             err_q;
   logic             busy_q;
   logic             done;

   // A frame start always shifts into a cleared register.
   always_comb begin
      sr_base = sr_q;
      if ((state_q == IDLE) || p.z) begin
         sr_base = '0;
      end
      if (MSB_FIRST) begin
         sr_d = (sr_base << 1) | WIDTH'(p.x);
      end else begin
         sr_d = (sr_base >> 1) | {p.x, {(WIDTH-1){1'b0}}};
      end
      done = p.y && !p.z && (state_q == SHIFT)
             && (bitcnt_q == LAST);
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         sr_q     <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (p.y) begin
            unique case (state_q)
               IDLE: begin
                  if (p.z) begin
                     sr_q     <= sr_d;
                     bitcnt_q <= BW'(1);
                     state_q  <= SHIFT;
                     busy_q   <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               SHIFT: begin
                  sr_q <= sr_d;
                  if (p.z) begin
                     err_q    <= 1'b1;
                     bitcnt_q <= BW'(1);
                  end else if (done) begin
                     data_q   <= sr_d;
                     valid_q  <= 1'b1;
                     bitcnt_q <= '0;
                     state_q  <= IDLE;
                     busy_q   <= 1'b0;
                  end else begin
                     bitcnt_q <= bitcnt_q + BW'(1);
                  end
               end
            endcase
         end
      end
   end

   svi_sat_counter #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .i_clk (i_clk),
      .i_srst(i_srst),
      .i_inc (done),
      .o_q   (o_count)
   );

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_err   = err_q;
   assign o_busy  = busy_q;

endmodule
